clk_cfg_seq: RTL and testbench
==============================

// Module: clk_cfg_seq
// PURPOSE
//  Glitch-safe configuration sequencer for the clock/reset manager mux/divider/ROSC selects.
//  Takes a config request (req/ack), parks the system clock on ROSC 8MHz, applies new selects,
//  then resumes the requested source, with a settle window at each step.
//  Also forces fail-safe fallback to ROSC 8MHz when the external-clock monitor flags a failure.
// PARAMETERS
//  SETTLE_CYC  16  clk cycles per settle window (>=2); counter width $clog2(SETTLE_CYC)
// PORTS
//  clk           in   1  always-on clock (ROSC 8MHz domain)
//  rst_n         in   1  reset, asynchronous, active-low
//  cfg_req       in   1  config request, level, held until cfg_ack
//  cfg_sel_mux0  in   1  requested CLKMUX0 select (0: 8MHz, 1: divided mux1 path)
//  cfg_sel_mux1  in   1  requested CLKMUX1 select (0: ROSC, 1: xclk)
//  cfg_sel_mux2  in   1  requested CLKMUX2 select (0: xclk0, 1: xclk1)
//  cfg_sel_rosc  in   2  requested ROSC frequency code
//  cfg_clk_div   in   2  requested divider code (/1,/2,/4,/8)
//  xclk_fail     in   1  external-clock failure, synchronous to clk
//  fail_clr      in   1  clears fail_flag
//  sel_mux0/sel_mux1/sel_mux2 out 1 each; sel_rosc, clk_div out 2 each: to clock manager
//  busy          out  1  sequence in progress
//  cfg_ack       out  1  one-cycle completion pulse
//  cfg_err       out  1  valid with cfg_ack: request rejected/aborted
//  fail_flag     out  1  sticky fail-safe indication
// BEHAVIOUR
//  - All outputs registered. Reset: all sel_*, clk_div, busy, cfg_ack, cfg_err, fail_flag = 0.
//  - States: IDLE, SET_P, SET_A, SET_R. Settle counter cnt loaded SETTLE_CYC-1 on state entry.
//  - IDLE & cfg_req (edge k): latch cfg_* into shadow; sel_mux0<=0; busy<=1; ->SET_P.
//  - SET_P, cnt==0 (edge k+S): sel_mux1/mux2/rosc/clk_div<=shadow; ->SET_A.
//  - SET_A, cnt==0 (edge k+2S): sel_mux0<=shadow mux0; ->SET_R.
//  - SET_R, cnt==0 (edge k+3S): cfg_ack<=1 (one cycle), cfg_err<=0, busy<=0; ->IDLE.
//  - Else in SET_*: cnt decrements. Total latency req->ack = 3*SETTLE_CYC cycles.
//  - Request equal to current config still runs full sequence (deterministic latency).
//  - cfg_req changes while busy: ignored; shadow frozen; no queuing.
//  - cfg_req still high in IDLE cycle after ack = new request (requester drops on ack).
//  - Async reset mid-sequence: outputs to reset values at once, no ack, state IDLE.
// CONFIGURATION
//  Macro CLK_CFG_SEQ_FAILSAFE_EN:
//  - Defined: xclk_fail sampled each cycle, any state. If xclk_fail & sel_mux1==1:
//    same edge sel_mux0<=0, sel_mux1<=0, fail_flag<=1, busy<=0, ->IDLE; if busy,
//    cfg_ack<=1 & cfg_err<=1. xclk_fail with sel_mux1==0: ignored (flag unchanged).
//  - While fail_flag=1, IDLE request with cfg_sel_mux1=1 is rejected: cfg_ack=cfg_err=1
//    next edge, outputs unchanged; cfg_sel_mux1=0 requests run normally.
//  - fail_clr clears fail_flag; fail_clr and flag-set same cycle: set wins.
//  - Undefined: xclk_fail and fail_clr ignored; fail_flag, cfg_err tied 0.
// TESTING (SETTLE_CYC=4, FAILSAFE_EN defined unless noted)
//  1 rst_n low -> all outputs 0; release, no req -> outputs stay 0, busy 0.
//  2 req mux0=1,mux1=1,mux2=1,rosc=2'b10,div=2'b11 at edge 0 -> sel_mux0 0 at edge 0,
//    selects applied edge 4, sel_mux0=1 edge 8, ack=1 err=0 edge 12 for 1 cycle, busy edges 0-11.
//  3 during test 2, change cfg_* and pulse req at edge 5 -> ignored; single ack at 12, values from edge 0.
//  4 after test 2, xclk_fail=1 one cycle -> next edge sel_mux0=0, sel_mux1=0, fail_flag=1,
//    mux2/rosc/div unchanged, no ack; repeat mid-sequence after edge 4 -> ack=1 err=1.
//  5 fail_flag=1: req mux1=1 -> ack+err next edge, no output change; req mux1=0,rosc=2'b11 ->
//    normal 12-cycle sequence; fail_clr with xclk_fail (sel_mux1=1) same cycle -> flag stays 1.
//  6 assert rst_n at edge 6 of a sequence -> outputs 0 immediately, no ack; macro undefined:
//    xclk_fail=1 with sel_mux1=1 -> no output change, fail_flag 0.

Source files
------------

// File: rtl/clk_cfg_seq.sv
// -----------------------------------------------------------------------------
// clk_cfg_seq
//
// Glitch-safe configuration sequencer for the clock/reset manager selects.
// A request (cfg_req held until cfg_ack) is handled in three settle windows:
//   SET_P : system clock parked on ROSC 8MHz (sel_mux0 = 0)
//   SET_A : new mux1/mux2/rosc/divider selects applied while parked
//   SET_R : sel_mux0 restored to the requested value, then cfg_ack pulses
// Each window lasts SETTLE_CYC clk cycles, so the latency from req to ack is
// always 3*SETTLE_CYC cycles, even when the request matches the current setup.
//
// Optional fail-safe (compile macro CLK_CFG_SEQ_FAILSAFE_EN):
//   xclk_fail while running from xclk (sel_mux1 = 1) forces sel_mux0/sel_mux1
//   to 0 (ROSC 8MHz), sets the sticky fail_flag and aborts any sequence with
//   cfg_ack + cfg_err. While fail_flag is set, requests for xclk are rejected.
//   Without the macro, xclk_fail/fail_clr are ignored and fail_flag/cfg_err
//   never assert.
//
// Parameters
//   SETTLE_CYC   clk cycles per settle window (>= 2)
// Ports
//   clk, rst_n                    always-on clock, async active-low reset
//   cfg_req                       level request, held until cfg_ack
//   cfg_sel_mux0/1/2, cfg_sel_rosc, cfg_clk_div   requested configuration
//   xclk_fail, fail_clr           external clock failure / flag clear
//   sel_mux0/1/2, sel_rosc, clk_div   registered selects to the clock manager
//   busy, cfg_ack, cfg_err, fail_flag  status (all registered)
// -----------------------------------------------------------------------------
module clk_cfg_seq #(
    parameter int SETTLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_req,
    input  logic       cfg_sel_mux0,
    input  logic       cfg_sel_mux1,
    input  logic       cfg_sel_mux2,
    input  logic [1:0] cfg_sel_rosc,
    input  logic [1:0] cfg_clk_div,
    input  logic       xclk_fail,
    input  logic       fail_clr,
    output logic       sel_mux0,
    output logic       sel_mux1,
    output logic       sel_mux2,
    output logic [1:0] sel_rosc,
    output logic [1:0] clk_div,
    output logic       busy,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       fail_flag
);

    localparam int              CW       = $clog2(SETTLE_CYC);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SET_P, SET_A, SET_R} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Shadow copy of the request, frozen for the whole sequence
    logic       sh_mux0_q, sh_mux0_d;
    logic       sh_mux1_q, sh_mux1_d;
    logic       sh_mux2_q, sh_mux2_d;
    logic [1:0] sh_rosc_q, sh_rosc_d;
    logic [1:0] sh_div_q,  sh_div_d;

    logic       sel_mux0_q, sel_mux0_d;
    logic       sel_mux1_q, sel_mux1_d;
    logic       sel_mux2_q, sel_mux2_d;
    logic [1:0] sel_rosc_q, sel_rosc_d;
    logic [1:0] clk_div_q,  clk_div_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       flag_q, flag_d;

    logic       fail_evt;     // failure while running from xclk
    logic       fail_clr_en;
    logic       req_reject;   // xclk request refused while fail_flag is set

`ifdef CLK_CFG_SEQ_FAILSAFE_EN
    assign fail_evt    = xclk_fail & sel_mux1_q;
    assign fail_clr_en = fail_clr;
    assign req_reject  = flag_q & cfg_sel_mux1;
`else
    assign fail_evt    = 1'b0;
    assign fail_clr_en = 1'b0;
    assign req_reject  = 1'b0;
    logic unused_failsafe_in;
    assign unused_failsafe_in = ^{xclk_fail, fail_clr};
`endif

    wire cnt_done = (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_mux0_q  <= 1'b0;
            sh_mux1_q  <= 1'b0;
            sh_mux2_q  <= 1'b0;
            sh_rosc_q  <= '0;
            sh_div_q   <= '0;
            sel_mux0_q <= 1'b0;
            sel_mux1_q <= 1'b0;
            sel_mux2_q <= 1'b0;
            sel_rosc_q <= '0;
            clk_div_q  <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_mux0_q  <= sh_mux0_d;
            sh_mux1_q  <= sh_mux1_d;
            sh_mux2_q  <= sh_mux2_d;
            sh_rosc_q  <= sh_rosc_d;
            sh_div_q   <= sh_div_d;
            sel_mux0_q <= sel_mux0_d;
            sel_mux1_q <= sel_mux1_d;
            sel_mux2_q <= sel_mux2_d;
            sel_rosc_q <= sel_rosc_d;
            clk_div_q  <= clk_div_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            flag_q     <= flag_d;
        end
    end

    // Next-state logic: settle counter reloads on every state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fail_evt) begin
            state_d = IDLE;
            cnt_d   = CNT_LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_req && !req_reject) begin
                        state_d = SET_P;
                        cnt_d   = CNT_LOAD;
                    end
                end
                SET_P: begin
                    if (cnt_done) begin
                        state_d = SET_A;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SET_A: begin
                    if (cnt_done) begin
                        state_d = SET_R;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SET_R: begin
                    if (cnt_done) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        sh_mux0_d  = sh_mux0_q;
        sh_mux1_d  = sh_mux1_q;
        sh_mux2_d  = sh_mux2_q;
        sh_rosc_d  = sh_rosc_q;
        sh_div_d   = sh_div_q;
        sel_mux0_d = sel_mux0_q;
        sel_mux1_d = sel_mux1_q;
        sel_mux2_d = sel_mux2_q;
        sel_rosc_d = sel_rosc_q;
        clk_div_d  = clk_div_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        // A failure in the same cycle as a clear keeps the flag set
        flag_d     = fail_evt ? 1'b1 : (fail_clr_en ? 1'b0 : flag_q);

        if (fail_evt) begin
            // Drop straight to ROSC 8MHz; other selects are left as they are
            sel_mux0_d = 1'b0;
            sel_mux1_d = 1'b0;
            busy_d     = 1'b0;
            if (busy_q) begin
                ack_d = 1'b1;
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_req) begin
                        if (req_reject) begin
                            ack_d = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            sh_mux0_d  = cfg_sel_mux0;
                            sh_mux1_d  = cfg_sel_mux1;
                            sh_mux2_d  = cfg_sel_mux2;
                            sh_rosc_d  = cfg_sel_rosc;
                            sh_div_d   = cfg_clk_div;
                            sel_mux0_d = 1'b0;
                            busy_d     = 1'b1;
                        end
                    end
                end
                SET_P: begin
                    if (cnt_done) begin
                        sel_mux1_d = sh_mux1_q;
                        sel_mux2_d = sh_mux2_q;
                        sel_rosc_d = sh_rosc_q;
                        clk_div_d  = sh_div_q;
                    end
                end
                SET_A: begin
                    if (cnt_done) sel_mux0_d = sh_mux0_q;
                end
                SET_R: begin
                    if (cnt_done) begin
                        ack_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_mux0  = sel_mux0_q;
    assign sel_mux1  = sel_mux1_q;
    assign sel_mux2  = sel_mux2_q;
    assign sel_rosc  = sel_rosc_q;
    assign clk_div   = clk_div_q;
    assign busy      = busy_q;
    assign cfg_ack   = ack_q;
    assign cfg_err   = err_q;
    assign fail_flag = flag_q;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_cfg_seq
//
// Self-checking bench for clk_cfg_seq with SETTLE_CYC = 4. Expected outputs
// come from a configuration model: the selects the clock manager should see,
// plus the spec's timeline of a request (park at edge 0, apply at S, restore
// at 2S, ack at 3S). Fail-safe scenarios are exercised when the bench is built
// with CLK_CFG_SEQ_FAILSAFE_EN; otherwise the inert behaviour is checked.
// -----------------------------------------------------------------------------
module tb_clk_cfg_seq;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic       cfg_sel_mux0 = 1'b0;
    logic       cfg_sel_mux1 = 1'b0;
    logic       cfg_sel_mux2 = 1'b0;
    logic [1:0] cfg_sel_rosc = '0;
    logic [1:0] cfg_clk_div = '0;
    logic       xclk_fail = 1'b0;
    logic       fail_clr = 1'b0;
    logic       sel_mux0, sel_mux1, sel_mux2;
    logic [1:0] sel_rosc, clk_div;
    logic       busy, cfg_ack, cfg_err, fail_flag;

    clk_cfg_seq #(.SETTLE_CYC(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_req      (cfg_req),
        .cfg_sel_mux0 (cfg_sel_mux0),
        .cfg_sel_mux1 (cfg_sel_mux1),
        .cfg_sel_mux2 (cfg_sel_mux2),
        .cfg_sel_rosc (cfg_sel_rosc),
        .cfg_clk_div  (cfg_clk_div),
        .xclk_fail    (xclk_fail),
        .fail_clr     (fail_clr),
        .sel_mux0     (sel_mux0),
        .sel_mux1     (sel_mux1),
        .sel_mux2     (sel_mux2),
        .sel_rosc     (sel_rosc),
        .clk_div      (clk_div),
        .busy         (busy),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .fail_flag    (fail_flag)
    );

    always #5 clk = ~clk;

    wire [10:0] obs = {sel_mux0, sel_mux1, sel_mux2, sel_rosc, clk_div,
                       busy, cfg_ack, cfg_err, fail_flag};

    // Model of what the clock manager should currently be configured to
    logic       m_mux0 = 1'b0, m_mux1 = 1'b0, m_mux2 = 1'b0, m_flag = 1'b0;
    logic [1:0] m_rosc = '0, m_div = '0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [10:0] pack(logic a, logic b, logic c, logic [1:0] r,
                                         logic [1:0] d, logic bz, logic ak,
                                         logic er, logic fl);
        return {a, b, c, r, d, bz, ak, er, fl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg;
        cfg_sel_mux0 = 1'($urandom_range(0, 1));
        cfg_sel_mux1 = 1'($urandom_range(0, 1));
        cfg_sel_mux2 = 1'($urandom_range(0, 1));
        cfg_sel_rosc = 2'($urandom_range(0, 3));
        cfg_clk_div  = 2'($urandom_range(0, 3));
    endtask

    // Issues the request currently on the cfg_* inputs; the next posedge is
    // edge 0. abort_kind: 0 none, 1 xclk_fail hits at edge abort_at,
    // 2 async reset asserted just after edge abort_at.
    task automatic run_seq(input bit scramble, input bit hold_after,
                           input int abort_at, input int abort_kind, input string tag);
        logic       n0, n1, n2;
        logic [1:0] nr, nd;
        logic [10:0] exp;
        n0 = cfg_sel_mux0; n1 = cfg_sel_mux1; n2 = cfg_sel_mux2;
        nr = cfg_sel_rosc; nd = cfg_clk_div;
        cfg_req = 1'b1;
        if (m_flag && n1) begin
            tick;
            exp = pack(m_mux0, m_mux1, m_mux2, m_rosc, m_div, 1'b0, 1'b1, 1'b1, m_flag);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s reject ack: got %b want %b", tag, obs, exp);
            end
            cfg_req = 1'b0;
            tick;
            exp = pack(m_mux0, m_mux1, m_mux2, m_rosc, m_div, 1'b0, 1'b0, 1'b0, m_flag);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s reject idle: got %b want %b", tag, obs, exp);
            end
            $display("%s: rejected request (fail_flag set)", tag);
            return;
        end
        for (int i = 0; i <= 3 * S; i++) begin
            tick;
            if (abort_kind == 1 && i == abort_at) begin
                xclk_fail = 1'b0;
                cfg_req   = 1'b0;
                m_mux0 = 1'b0;
                m_mux1 = 1'b0;
                if (i >= S) begin
                    m_mux2 = n2; m_rosc = nr; m_div = nd;
                end
                m_flag = 1'b1;
                exp = pack(m_mux0, m_mux1, m_mux2, m_rosc, m_div, 1'b0, 1'b1, 1'b1, 1'b1);
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL %s abort edge %0d: got %b want %b", tag, i, obs, exp);
                end
                tick;
                exp = pack(m_mux0, m_mux1, m_mux2, m_rosc, m_div, 1'b0, 1'b0, 1'b0, 1'b1);
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL %s after abort: got %b want %b", tag, obs, exp);
                end
                $display("%s: aborted by xclk_fail at edge %0d", tag, i);
                return;
            end
            exp = pack((i >= 2 * S) ? n0 : 1'b0,
                       (i >= S) ? n1 : m_mux1,
                       (i >= S) ? n2 : m_mux2,
                       (i >= S) ? nr : m_rosc,
                       (i >= S) ? nd : m_div,
                       (i < 3 * S) ? 1'b1 : 1'b0,
                       (i == 3 * S) ? 1'b1 : 1'b0,
                       1'b0, m_flag);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s edge %0d: got %b want %b", tag, i, obs, exp);
            end
            if (abort_kind == 1 && i == abort_at - 1) xclk_fail = 1'b1;
            if (abort_kind == 2 && i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                n_vec++;
                if (obs !== 11'd0) begin
                    n_err++;
                    $display("FAIL %s async reset: got %b want %b", tag, obs, 11'd0);
                end
                cfg_req = 1'b0;
                tick;
                rst_n = 1'b1;
                m_mux0 = 1'b0; m_mux1 = 1'b0; m_mux2 = 1'b0;
                m_rosc = '0; m_div = '0; m_flag = 1'b0;
                for (int j = 0; j < 2 * S; j++) begin
                    tick;
                    n_vec++;
                    if (obs !== 11'd0) begin
                        n_err++;
                        $display("FAIL %s post-reset cyc %0d: got %b want %b", tag, j, obs, 11'd0);
                    end
                end
                $display("%s: reset asserted at edge %0d, no ack", tag, i);
                return;
            end
            if (scramble && i < 3 * S) begin
                rand_cfg;
                cfg_req = 1'($urandom_range(0, 1));
            end
        end
        m_mux0 = n0; m_mux1 = n1; m_mux2 = n2; m_rosc = nr; m_div = nd;
        if (!hold_after) cfg_req = 1'b0;
        $display("%s: cfg m0=%0d m1=%0d m2=%0d rosc=%0d div=%0d acked", tag, n0, n1, n2, nr, nd);
    endtask

    task automatic check_idle(input string tag);
        logic [10:0] exp;
        exp = pack(m_mux0, m_mux1, m_mux2, m_rosc, m_div, 1'b0, 1'b0, 1'b0, m_flag);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
        $display("%s: outputs %b", tag, obs);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 11'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %b want %b", obs, 11'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_idle("reset_release");
        end
    endtask

    task automatic test_sequence;
        cfg_sel_mux0 = 1'b1; cfg_sel_mux1 = 1'b1; cfg_sel_mux2 = 1'b1;
        cfg_sel_rosc = 2'b10; cfg_clk_div = 2'b11;
        run_seq(1'b1, 1'b0, -1, 0, "seq_fixed");
        tick;
        check_idle("seq_fixed_after");
    endtask

    task automatic test_back_to_back;
        rand_cfg;
        run_seq(1'b0, 1'b1, -1, 0, "b2b_first");
        rand_cfg;
        run_seq(1'b0, 1'b0, -1, 0, "b2b_second");
        tick;
        check_idle("b2b_after");
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++) begin
            rand_cfg;
            if ($urandom_range(0, 3) == 0) begin
                cfg_sel_mux0 = m_mux0; cfg_sel_mux1 = m_mux1; cfg_sel_mux2 = m_mux2;
                cfg_sel_rosc = m_rosc; cfg_clk_div = m_div;
            end
            run_seq(1'b1, 1'b0, -1, 0, "rand");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick;
                check_idle("rand_gap");
            end
        end
    endtask

`ifdef CLK_CFG_SEQ_FAILSAFE_EN
    task automatic test_failsafe;
        rand_cfg; cfg_sel_mux1 = 1'b1;
        run_seq(1'b0, 1'b0, -1, 0, "fs_setup");
        xclk_fail = 1'b1;
        tick;
        xclk_fail = 1'b0;
        m_mux0 = 1'b0; m_mux1 = 1'b0; m_flag = 1'b1;
        check_idle("fs_idle_fail");
        tick;
        check_idle("fs_idle_fail_noack");
        rand_cfg; cfg_sel_mux1 = 1'b1;
        run_seq(1'b0, 1'b0, -1, 0, "fs_reject");
        rand_cfg; cfg_sel_mux1 = 1'b0; cfg_sel_rosc = 2'b11;
        run_seq(1'b0, 1'b0, -1, 0, "fs_rosc_ok");
        xclk_fail = 1'b1;
        tick;
        xclk_fail = 1'b0;
        check_idle("fs_fail_on_rosc");
        fail_clr = 1'b1;
        tick;
        fail_clr = 1'b0;
        m_flag = 1'b0;
        check_idle("fs_clear");
        rand_cfg; cfg_sel_mux1 = 1'b1;
        run_seq(1'b0, 1'b0, 6, 1, "fs_abort");
        fail_clr = 1'b1;
        tick;
        fail_clr = 1'b0;
        m_flag = 1'b0;
        check_idle("fs_clear2");
        rand_cfg; cfg_sel_mux1 = 1'b1;
        run_seq(1'b0, 1'b0, -1, 0, "fs_setup2");
        xclk_fail = 1'b1; fail_clr = 1'b1;
        tick;
        xclk_fail = 1'b0; fail_clr = 1'b0;
        m_mux0 = 1'b0; m_mux1 = 1'b0; m_flag = 1'b1;
        check_idle("fs_set_wins");
        fail_clr = 1'b1;
        tick;
        fail_clr = 1'b0;
        m_flag = 1'b0;
        check_idle("fs_final_clear");
    endtask
`else
    task automatic test_failsafe_off;
        rand_cfg; cfg_sel_mux1 = 1'b1;
        run_seq(1'b0, 1'b0, -1, 0, "nofs_setup");
        xclk_fail = 1'b1;
        tick;
        check_idle("nofs_fail_ignored");
        fail_clr = 1'b1;
        tick;
        xclk_fail = 1'b0; fail_clr = 1'b0;
        check_idle("nofs_clr_ignored");
    endtask
`endif

    task automatic test_async_reset;
        rand_cfg;
        run_seq(1'b0, 1'b0, 6, 2, "async_rst");
    endtask

    initial begin
        test_reset;
        test_sequence;
        test_back_to_back;
        test_random;
`ifdef CLK_CFG_SEQ_FAILSAFE_EN
        test_failsafe;
`else
        test_failsafe_off;
`endif
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
